ysyx_25040118_lsu_mc: RTL and testbench
=======================================

YSYX_25040118_LSU_MC -- requirements
Module: ysyx_25040118_lsu_mc

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h80000000, virtual base subtracted to form physical address.
REQ-002 SHALL have parameter MEM_SIZE, default 32'h08000000, legal byte range [MEM_BASE, MEM_BASE+MEM_SIZE).
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles in ISSUE+WAIT before fault.
REQ-004 SHALL have parameter ALIGN_CHECK, default 1, 1 enables misalignment trap, 0 lets misaligned accesses pass unchecked.
REQ-005 Ports: clk in 1 clock; rst in 1, single clock domain, reset synchronous active-high.
REQ-006 Ports: req_valid in 1; req_ready out 1; req_is_load in 1; req_is_store in 1; req_funct3 in 3; req_src1 in 32; req_src2 in 32; req_imm in 32.
REQ-007 Ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32 extended load data; resp_err out 2 (00 ok, 01 misaligned, 10 access fault, 11 illegal).
REQ-008 Ports: mem_valid out 1; mem_ready in 1; mem_we out 1; mem_addr out 32 physical word-aligned; mem_wdata out 32; mem_wmask out 4; mem_rsp_valid in 1; mem_rsp_rdata in 32; mem_rsp_err in 1.

Function
REQ-009 SHALL be a 4-state FSM: IDLE, ISSUE, WAIT, RESP; one transaction outstanding max.
REQ-010 req_ready SHALL be 1 only in IDLE; request accepted on req_valid&&req_ready; all request fields registered at accept.
REQ-011 Address SHALL be va=src1+imm (32-bit wrap); pa=va-MEM_BASE; mem_addr={pa[31:2],2'b00}; off=va[1:0].
REQ-012 Illegal (err 11): both or neither of is_load/is_store; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
REQ-013 Misaligned (err 01, when ALIGN_CHECK=1): halfword with off[0]=1; word with off!=0; with ALIGN_CHECK=0, a misaligned access SHALL issue without trap, mem_wmask truncated to 4 bits (bits shifted past lane 3 dropped) and load extraction using rdata>>(8*off).
REQ-014 Range fault (err 10): va outside [MEM_BASE, MEM_BASE+MEM_SIZE).
REQ-015 Error priority SHALL be illegal > misaligned > range; any error: IDLE->RESP next cycle, no mem_valid issued, resp_rdata=0.
REQ-016 Otherwise IDLE->ISSUE; ISSUE holds mem_valid=1 and mem_* stable until mem_ready; on mem_ready -> WAIT.
REQ-017 Store: mem_we=1; mem_wmask = (sb 0001, sh 0011, sw 1111) << off; mem_wdata = src2 << (8*off). Load: mem_we=0, mem_wmask=0000.
REQ-018 mem_rsp_valid SHALL be sampled only in WAIT (write ack for stores, data for loads); ignored in IDLE/ISSUE/RESP.
REQ-019 WAIT + mem_rsp_valid -> RESP; mem_rsp_err=1 gives err 10, rdata 0; else load rdata = (mem_rsp_rdata >> 8*off) then lb/lh sign-extend, lbu/lhu zero-extend, lw as-is; store rdata 0.
REQ-020 Timeout counter SHALL clear on accept, increment each cycle in ISSUE/WAIT; at count==TIMEOUT -> RESP err 10, mem_valid dropped; late responses ignored.
REQ-021 RESP holds resp_valid, resp_rdata, resp_err stable until resp_ready; handshake -> IDLE; new request accepted earliest the following cycle.
REQ-022 Minimum latency: accept T0, mem_valid T1, mem_ready T1, mem_rsp_valid T2, resp_valid T3; error path resp_valid at T1.
REQ-023 mem_valid SHALL be 1 only in ISSUE; all outputs registered (no comb path from mem_rsp_* to resp_*).

Reset
REQ-024 rst at posedge SHALL force IDLE, counter 0, req_ready=1 (after reset), resp_valid=0, resp_rdata=0, resp_err=00, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
REQ-025 Reset mid-transaction SHALL abandon it; subsequent mem_rsp_valid for it ignored.

Verification
REQ-026 lb: src1=0x80000100, imm=3, mem_rsp_rdata=0x80AABBCC -> mem_addr=0x100, resp_rdata=0xFFFFFF80, err 00.
REQ-027 sh: src1=0x80000002, imm=0, src2=0x1234 -> mem_wmask=1100, mem_wdata=0x12340000, mem_we=1, then resp err 00.
REQ-028 lw va=0x80000006 -> resp err 01 at T1, mem_valid never asserted; with ALIGN_CHECK=0 -> issued, mem_addr=0x4.
REQ-029 mem_ready held 0 for 300 cycles, TIMEOUT=255 -> resp err 10 after 256 cycles in ISSUE; later mem_rsp_valid ignored.
REQ-030 resp_ready held 0 five cycles, then rst in WAIT on next op -> RESP stable throughout; after rst all outputs per REQ-024, next lbu returns 0x000000CC correctly.

Source files
------------

// File: rtl/ysyx_25040118_lsu_mc_if.sv
// Bus bundle for the multi-cycle LSU: request/response channel toward the core
// and the single-outstanding memory channel. The LSU uses the slave view.
interface ysyx_25040118_lsu_mc_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [31:0] req_imm;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_funct3, req_src1, req_src2, req_imm,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    modport master (
        output req_valid, req_is_load, req_is_store, req_funct3, req_src1, req_src2, req_imm,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/ysyx_25040118_lsu_mc.sv
// Multi-cycle load/store unit: one transaction at a time, address/alignment/range
// checking at accept, byte-lane steering, bounded wait on the memory side.
//
//   state | meaning
//   IDLE  | req_ready=1, waiting for a request
//   ISSUE | mem_valid=1 with stable address/data until mem_ready
//   WAIT  | waiting for mem_rsp_valid (write ack or load data)
//   RESP  | resp_valid=1 held until resp_ready
module ysyx_25040118_lsu_mc #(
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE    = 32'h0800_0000,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_25040118_lsu_mc_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FAULT    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_err_q, resp_err_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;

    // Request decode, evaluated on the live request fields during IDLE.
    logic [31:0] va, pa, req_wdata;
    logic [1:0]  off;
    logic [3:0]  base_mask, req_wmask;
    logic        illegal, misaligned, out_of_range;
    logic [1:0]  req_err;

    always_comb begin
        va           = bus.req_src1 + bus.req_imm;
        pa           = va - MEM_BASE;
        off          = va[1:0];
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        if (bus.req_is_load == bus.req_is_store) begin
            illegal = 1'b1;
        end else if (bus.req_is_load) begin
            illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end
        if (ALIGN_CHECK != 0) begin
            misaligned = ((bus.req_funct3[1:0] == 2'b01) && off[0]) ||
                         ((bus.req_funct3[1:0] == 2'b10) && (off != 2'b00));
        end
        // Addresses below MEM_BASE wrap to a large pa and fail the same compare.
        out_of_range = (pa >= MEM_SIZE);

        if (illegal)           req_err = ERR_ILLEGAL;
        else if (misaligned)   req_err = ERR_MISALIGN;
        else if (out_of_range) req_err = ERR_FAULT;
        else                   req_err = ERR_OK;

        case (bus.req_funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        req_wmask = base_mask << off;
        req_wdata = bus.req_src2 << {off, 3'b000};
    end

    // Load data extraction from the registered lane offset and size.
    logic [31:0] rsp_shifted, load_data;

    always_comb begin
        rsp_shifted = bus.mem_rsp_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  load_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100:  load_data = {24'd0, rsp_shifted[7:0]};
            3'b101:  load_data = {16'd0, rsp_shifted[15:0]};
            default: load_data = rsp_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        off_d        = off_q;
        funct3_d     = funct3_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    cnt_d    = '0;
                    off_d    = off;
                    funct3_d = bus.req_funct3;
                    if (req_err != ERR_OK) begin
                        state_d      = S_RESP;
                        resp_err_d   = req_err;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_addr_d  = {pa[31:2], 2'b00};
                        mem_we_d    = bus.req_is_store;
                        mem_wmask_d = bus.req_is_store ? req_wmask : 4'b0000;
                        mem_wdata_d = bus.req_is_store ? req_wdata : 32'd0;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 32'd1;
                if (bus.mem_ready) begin
                    state_d = S_WAIT;
                end else if (cnt_q >= TIMEOUT) begin
                    state_d      = S_RESP;
                    resp_err_d   = ERR_FAULT;
                    resp_rdata_d = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (bus.mem_rsp_valid) begin
                    state_d = S_RESP;
                    if (bus.mem_rsp_err) begin
                        resp_err_d   = ERR_FAULT;
                        resp_rdata_d = '0;
                    end else begin
                        resp_err_d   = ERR_OK;
                        resp_rdata_d = mem_we_q ? 32'd0 : load_data;
                    end
                end else if (cnt_q >= TIMEOUT) begin
                    // Handshake ISSUE->WAIT may land past TIMEOUT, hence >=.
                    state_d      = S_RESP;
                    resp_err_d   = ERR_FAULT;
                    resp_rdata_d = '0;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        mem_valid_d  = (state_d == S_ISSUE);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
            off_q        <= '0;
            funct3_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_ysyx_25040118_lsu_mc.sv
// Directed bench for the multi-cycle LSU: a vector table of single transactions
// plus hand sequences for timeout, response back-pressure, reset and no-align mode.
module tb_ysyx_25040118_lsu_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25040118_lsu_mc_if bus ();
    ysyx_25040118_lsu_mc_if bus2 ();

    ysyx_25040118_lsu_mc dut (.clk(clk), .rst(rst), .bus(bus));
    ysyx_25040118_lsu_mc #(.ALIGN_CHECK(0)) dut_na (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic        issue;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string n, logic ld, logic st, logic [2:0] f3,
                                logic [31:0] s1, logic [31:0] s2, logic [31:0] imm,
                                logic iss, logic [31:0] ea, logic [3:0] em, logic [31:0] ew,
                                logic [31:0] rr, logic re, logic [1:0] ee, logic [31:0] er);
        vec_t v;
        v.name = n; v.ld = ld; v.st = st; v.f3 = f3;
        v.src1 = s1; v.src2 = s2; v.imm = imm;
        v.issue = iss; v.exp_addr = ea; v.exp_wmask = em; v.exp_wdata = ew;
        v.rsp_rdata = rr; v.rsp_err = re; v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_valid    = 1'b1;
        bus.req_is_load  = v.ld;
        bus.req_is_store = v.st;
        bus.req_funct3   = v.f3;
        bus.req_src1     = v.src1;
        bus.req_src2     = v.src2;
        bus.req_imm      = v.imm;
    endtask

    task automatic run_vec(input vec_t v);
        chk({v.name, " req_ready"}, 32'(bus.req_ready), 32'd1);
        drive_req(v);
        step();
        bus.req_valid = 1'b0;
        if (v.issue) begin
            chk({v.name, " mem_valid"}, 32'(bus.mem_valid), 32'd1);
            chk({v.name, " early_resp"}, 32'(bus.resp_valid), 32'd0);
            chk({v.name, " mem_addr"}, bus.mem_addr, v.exp_addr);
            chk({v.name, " mem_we"}, 32'(bus.mem_we), 32'(v.st));
            chk({v.name, " mem_wmask"}, 32'(bus.mem_wmask), 32'(v.exp_wmask));
            if (v.st) chk({v.name, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
            bus.mem_ready = 1'b1;
            step();
            bus.mem_ready = 1'b0;
            chk({v.name, " wait_mem_valid"}, 32'(bus.mem_valid), 32'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = v.rsp_rdata;
            bus.mem_rsp_err   = v.rsp_err;
            step();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_err   = 1'b0;
        end else begin
            chk({v.name, " no_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        end
        chk({v.name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({v.name, " resp_err"}, 32'(bus.resp_err), 32'(v.exp_err));
        chk({v.name, " resp_rdata"}, bus.resp_rdata, v.exp_rdata);
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk({v.name, " resp_done"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic reset_inputs();
        bus.req_valid = 0; bus.req_is_load = 0; bus.req_is_store = 0; bus.req_funct3 = 0;
        bus.req_src1 = 0; bus.req_src2 = 0; bus.req_imm = 0; bus.resp_ready = 0;
        bus.mem_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0; bus.mem_rsp_err = 0;
        bus2.req_valid = 0; bus2.req_is_load = 0; bus2.req_is_store = 0; bus2.req_funct3 = 0;
        bus2.req_src1 = 0; bus2.req_src2 = 0; bus2.req_imm = 0; bus2.resp_ready = 0;
        bus2.mem_ready = 0; bus2.mem_rsp_valid = 0; bus2.mem_rsp_rdata = 0; bus2.mem_rsp_err = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
        chk({tag, " mem_valid"}, 32'(bus.mem_valid), 32'd0);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, " mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //        name                ld st f3      src1          src2          imm           iss addr          wmask    wdata         rsp_rdata     re err    rdata
        vecs.push_back(mk("lb_neg",      1, 0, 3'b000, 32'h80000100, 32'h0,        32'd3,        1, 32'h100,      4'b0000, 32'h0,        32'h80AABBCC, 0, 2'b00, 32'hFFFFFF80));
        vecs.push_back(mk("sh_off2",     0, 1, 3'b001, 32'h80000002, 32'h1234,     32'd0,        1, 32'h0,        4'b1100, 32'h12340000, 32'h0,        0, 2'b00, 32'h0));
        vecs.push_back(mk("lw_misal",    1, 0, 3'b010, 32'h80000004, 32'h0,        32'd2,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01, 32'h0));
        vecs.push_back(mk("lbu",         1, 0, 3'b100, 32'h80000010, 32'h0,        32'd0,        1, 32'h10,       4'b0000, 32'h0,        32'h123456CC, 0, 2'b00, 32'h000000CC));
        vecs.push_back(mk("lh_off2",     1, 0, 3'b001, 32'h80000020, 32'h0,        32'd2,        1, 32'h20,       4'b0000, 32'h0,        32'h80011234, 0, 2'b00, 32'hFFFF8001));
        vecs.push_back(mk("lhu_off2",    1, 0, 3'b101, 32'h80000020, 32'h0,        32'd2,        1, 32'h20,       4'b0000, 32'h0,        32'h80011234, 0, 2'b00, 32'h00008001));
        vecs.push_back(mk("lw_negimm",   1, 0, 3'b010, 32'h80001000, 32'h0,        32'hFFFFFFFC, 1, 32'hFFC,      4'b0000, 32'h0,        32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF));
        vecs.push_back(mk("sw",          0, 1, 3'b010, 32'h80000040, 32'hCAFEF00D, 32'd4,        1, 32'h44,       4'b1111, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 2'b00, 32'h0));
        vecs.push_back(mk("sb_off1",     0, 1, 3'b000, 32'h80000041, 32'h112233AB, 32'd0,        1, 32'h40,       4'b0010, 32'h2233AB00, 32'h0,        0, 2'b00, 32'h0));
        vecs.push_back(mk("lb_off1",     1, 0, 3'b000, 32'h80000031, 32'h0,        32'd0,        1, 32'h30,       4'b0000, 32'h0,        32'h0000F100, 0, 2'b00, 32'hFFFFFFF1));
        vecs.push_back(mk("lb_pos",      1, 0, 3'b000, 32'h80000008, 32'h0,        32'd0,        1, 32'h8,        4'b0000, 32'h0,        32'h0000007F, 0, 2'b00, 32'h0000007F));
        vecs.push_back(mk("below_base",  1, 0, 3'b010, 32'h7FFFFFFC, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b10, 32'h0));
        vecs.push_back(mk("past_end",    1, 0, 3'b010, 32'h88000000, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b10, 32'h0));
        vecs.push_back(mk("last_word",   1, 0, 3'b010, 32'h87FFFFFC, 32'h0,        32'd0,        1, 32'h07FFFFFC, 4'b0000, 32'h0,        32'h01020304, 0, 2'b00, 32'h01020304));
        vecs.push_back(mk("ld_and_st",   1, 1, 3'b010, 32'h80000000, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11, 32'h0));
        vecs.push_back(mk("neither",     0, 0, 3'b000, 32'h80000000, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11, 32'h0));
        vecs.push_back(mk("ld_f3_011",   1, 0, 3'b011, 32'h80000000, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11, 32'h0));
        vecs.push_back(mk("st_f3_100",   0, 1, 3'b100, 32'h80000000, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11, 32'h0));
        vecs.push_back(mk("ill_over_mis",0, 1, 3'b011, 32'h80000001, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b11, 32'h0));
        vecs.push_back(mk("mis_over_rng",1, 0, 3'b010, 32'h00000002, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01, 32'h0));
        vecs.push_back(mk("sh_off1",     0, 1, 3'b001, 32'h80000001, 32'h5555,     32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01, 32'h0));
        vecs.push_back(mk("lhu_off3",    1, 0, 3'b101, 32'h80000003, 32'h0,        32'd0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 2'b01, 32'h0));
        vecs.push_back(mk("bus_err",     1, 0, 3'b010, 32'h80000200, 32'h0,        32'd0,        1, 32'h200,      4'b0000, 32'h0,        32'hFFFFFFFF, 1, 2'b10, 32'h0));

        reset_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_reset_outputs("por");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Timeout: mem_ready never rises; 256 cycles in ISSUE, then fault.
        v = mk("to_lw", 1, 0, 3'b010, 32'h80000300, 32'h0, 32'd0, 1, 32'h300, 4'b0, 32'h0, 32'h0, 0, 2'b10, 32'h0);
        drive_req(v);
        step();
        bus.req_valid = 1'b0;
        repeat (255) step();
        chk("to last_issue_cycle mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("to last_issue_cycle resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("to mem_addr_stable", bus.mem_addr, 32'h300);
        step();
        chk("to resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("to resp_err", 32'(bus.resp_err), 32'd2);
        chk("to mem_valid_dropped", 32'(bus.mem_valid), 32'd0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h12345678;
        repeat (3) step();
        chk("to late_rsp err", 32'(bus.resp_err), 32'd2);
        chk("to late_rsp rdata", bus.resp_rdata, 32'd0);
        bus.mem_rsp_valid = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("to idle_rsp_ignored", 32'(bus.resp_valid), 32'd0);
        chk("to idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Response back-pressure: RESP stays stable while resp_ready is low.
        v = mk("bp_lw", 1, 0, 3'b010, 32'h80000504, 32'h0, 32'd0, 1, 32'h504, 4'b0, 32'h0, 32'h5A5A1234, 0, 2'b00, 32'h5A5A1234);
        drive_req(v);
        step();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h5A5A1234;
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk("bp resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp resp_rdata", bus.resp_rdata, 32'h5A5A1234);
            chk("bp resp_err", 32'(bus.resp_err), 32'd0);
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;

        // Reset while a store sits in WAIT; its later response must be ignored.
        v = mk("rst_sw", 0, 1, 3'b010, 32'h80000508, 32'hA5A5A5A5, 32'd0, 1, 32'h508, 4'b1111, 32'hA5A5A5A5, 32'h0, 0, 2'b00, 32'h0);
        drive_req(v);
        step();
        bus.req_valid = 1'b0;
        chk("rst_sw mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("rst_sw in_wait req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        bus.mem_rsp_valid = 1'b1;
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("midrst stale_rsp", 32'(bus.resp_valid), 32'd0);
        run_vec(mk("post_rst_lbu", 1, 0, 3'b100, 32'h80000600, 32'h0, 32'd0, 1, 32'h600, 4'b0, 32'h0, 32'h112233CC, 0, 2'b00, 32'h000000CC));

        // Alignment checking disabled: misaligned accesses issue normally.
        bus2.req_valid = 1'b1; bus2.req_is_load = 1'b1; bus2.req_is_store = 1'b0;
        bus2.req_funct3 = 3'b010; bus2.req_src1 = 32'h80000004; bus2.req_imm = 32'd2;
        step();
        bus2.req_valid = 1'b0;
        chk("na_lw mem_valid", 32'(bus2.mem_valid), 32'd1);
        chk("na_lw mem_addr", bus2.mem_addr, 32'h4);
        bus2.mem_ready = 1'b1;
        step();
        bus2.mem_ready = 1'b0;
        bus2.mem_rsp_valid = 1'b1;
        bus2.mem_rsp_rdata = 32'hAABBCCDD;
        step();
        bus2.mem_rsp_valid = 1'b0;
        chk("na_lw resp_valid", 32'(bus2.resp_valid), 32'd1);
        chk("na_lw resp_err", 32'(bus2.resp_err), 32'd0);
        chk("na_lw resp_rdata", bus2.resp_rdata, 32'h0000AABB);
        bus2.resp_ready = 1'b1;
        step();
        bus2.resp_ready = 1'b0;

        bus2.req_valid = 1'b1; bus2.req_is_load = 1'b0; bus2.req_is_store = 1'b1;
        bus2.req_funct3 = 3'b010; bus2.req_src1 = 32'h80000003; bus2.req_imm = 32'd0;
        bus2.req_src2 = 32'h11223344;
        step();
        bus2.req_valid = 1'b0;
        chk("na_sw mem_valid", 32'(bus2.mem_valid), 32'd1);
        chk("na_sw mem_addr", bus2.mem_addr, 32'h0);
        chk("na_sw mem_wmask", 32'(bus2.mem_wmask), 32'h8);
        chk("na_sw mem_wdata", bus2.mem_wdata, 32'h44000000);
        bus2.mem_ready = 1'b1;
        step();
        bus2.mem_ready = 1'b0;
        bus2.mem_rsp_valid = 1'b1;
        step();
        bus2.mem_rsp_valid = 1'b0;
        chk("na_sw resp_err", 32'(bus2.resp_err), 32'd0);
        chk("na_sw resp_rdata", bus2.resp_rdata, 32'd0);
        bus2.resp_ready = 1'b1;
        step();
        bus2.resp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
